add_sequencer: RTL
==================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 Parameter N, default 4, width of one adder slice in bits (N >= 1).
REQ-002 Parameter WORDS, default 4, number of slices per operand (WORDS >= 2); total operand width W = N*WORDS.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand pair a/b (and sub when compiled in) presented.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 a  input  W  first operand, unsigned.
REQ-008 b  input  W  second operand, unsigned.
REQ-009 sub  input  1  operation select, 1 = a-b (present only with ADD_SEQ_SUB_EN).
REQ-010 out_valid  output  1  sum/cout hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 sum  output  W  result, slice k at bits [N*k+N-1 : N*k].
REQ-013 cout  output  1  carry out of the most significant slice.
REQ-014 busy  output  1  high while slices are being computed (state RUN).

Function
REQ-015 Block SHALL compute the W-bit sum with a single N-bit ripple adder slice (full-adder per bit, carry-in from a registered carry) reused once per cycle, least significant slice first.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE, busy = 1 only in RUN, out_valid = 1 only in DONE.
REQ-017 IDLE: in_valid=1 SHALL latch a, b (and sub), clear slice index to 0, load carry register with 0 (add) or 1 (subtract), go to RUN; in_valid=0 stays IDLE.
REQ-018 RUN: each cycle SHALL write slice[index] of sum from a_slice + b_slice' + carry, store carry-out, increment index; on the cycle index == WORDS-1 go to DONE.
REQ-019 Latency SHALL be exactly WORDS+1 rising edges from the accepting edge to out_valid=1 (WORDS edges in RUN, then DONE visible).
REQ-020 DONE: sum and cout SHALL hold stable until out_valid & out_ready, after which the next state is IDLE; in_valid is ignored in RUN and DONE (no back-to-back acceptance).
REQ-021 Latched operands SHALL not change during RUN/DONE even if a, b, in_valid change.
REQ-022 Arithmetic is modulo 2^W; cout = carry out of bit W-1, no other overflow indication.
REQ-023 Slice index SHALL be ceil(log2(WORDS)) bits wide, minimum 1, and never exceed WORDS-1.
REQ-024 sum SHALL be cleared to 0 on acceptance; unwritten slices read 0 during RUN.

Reset
REQ-025 rst=1 at a rising edge SHALL force state IDLE, index 0, carry 0, sum 0, cout 0, in_ready 1, out_valid 0, busy 0, regardless of state.
REQ-026 Reset during RUN or DONE SHALL abandon the operation with no result delivered; first acceptance possible on the first edge with rst=0.

Configuration
REQ-027 Macro ADD_SEQ_SUB_EN defined: sub port exists; sub=1 SHALL use bitwise-inverted b slices and initial carry 1 (a-b two's complement, cout=1 means no borrow).
REQ-028 Macro ADD_SEQ_SUB_EN undefined: sub port absent, operation is always a+b with initial carry 0, no inversion logic.

Verification
REQ-029 N=4, WORDS=4: a=0x1234, b=0x4321, in_valid one cycle -> out_valid after exactly 5 edges, sum=0x5555, cout=0.
REQ-030 a=0xFFFF, b=0x0001 -> carry ripples across all four slices, sum=0x0000, cout=1.
REQ-031 Result held with out_ready=0 for 10 cycles, a/b/in_valid toggled meanwhile -> sum/cout constant, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-032 rst pulsed during RUN at index 2 -> next edge all outputs at reset values; new op 0x0001+0x0002 -> sum=0x0003.
REQ-033 ADD_SEQ_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-034 Random a/b, 1000 ops, random out_ready stalls -> every sum/cout matches (a+b) mod 2^16 and bit 16 of a+b.

Source files
------------

// File: rtl/add_sequencer.sv
// Multi-cycle W-bit adder built from one N-bit ripple slice reused once per cycle, LSB slice first.
// Optional subtract mode (a-b) compiled in with the ADD_SEQ_SUB_EN macro.
module add_sequencer #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
`ifdef ADD_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 busy
);

    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;
`ifdef ADD_SEQ_SUB_EN
    logic             sub_q;
`endif

    logic [N-1:0]     slice_a;
    logic [N-1:0]     slice_b;
    logic [N:0]       carry_chain;
    logic [N-1:0]     slice_sum_d;

    // One N-bit ripple slice selected by the current index, carry-in from the carry register.
    always_comb begin
        slice_a        = a_q[idx_q*N +: N];
        slice_b        = b_q[idx_q*N +: N];
`ifdef ADD_SEQ_SUB_EN
        slice_b        = slice_b ^ {N{sub_q}};
`endif
        carry_chain    = '0;
        carry_chain[0] = carry_q;
        slice_sum_d    = '0;
        for (int i = 0; i < N; i++) begin
            slice_sum_d[i]    = slice_a[i] ^ slice_b[i] ^ carry_chain[i];
            carry_chain[i+1]  = (slice_a[i] & slice_b[i]) |
                                (carry_chain[i] & (slice_a[i] ^ slice_b[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
                        sub_q      <= sub;
                        carry_q    <= sub;
`else
                        carry_q    <= 1'b0;
`endif
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[idx_q*N +: N] <= slice_sum_d;
                    carry_q             <= carry_chain[N];
                    // Index holds at the last slice so it never exceeds WORDS-1.
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= carry_chain[N];
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
